// File: rtl/mlp_seq_ctrl.sv
// Sequential 6-3-3 ReLU MLP classifier: one signed MAC walks an external coefficient ROM.
// Define MLP_SEQ_SAT_EN to clamp oversized ReLU results instead of truncating them.
module mlp_seq_ctrl #(
  parameter int N_IN  = 6,
  parameter int N_HID = 3,
  parameter int N_OUT = 3,
  parameter int IN_W  = 5,
  parameter int W_W   = 8,
  parameter int ACC_W = 20,
  parameter int HID_W = 12,
  parameter int OUT_W = 19,
  // The layer-1 map ends at address 32, so six address bits are needed.
  parameter int CA_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_data,
  output logic [CA_W-1:0]        coef_addr,
  input  logic [ACC_W-1:0]       coef_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_class,
  output logic [N_OUT*OUT_W-1:0] out_scores,
  output logic                   busy
);

  localparam int TERM_W  = $clog2(N_IN);
  localparam int NRN_W   = $clog2((N_HID > N_OUT) ? N_HID : N_OUT);
  localparam int L1_BASE = N_HID * (N_IN + 1);

  typedef enum logic [2:0] {IDLE, BIAS, MAC, WB, ARGMAX, DONE} state_t;

  state_t                   state, state_nx;
  logic                     layer;
  logic [NRN_W-1:0]         neuron;
  logic [TERM_W-1:0]        term;
  logic [IN_W-1:0]          feat  [N_IN];
  logic [HID_W-1:0]         hid   [N_HID];
  logic [OUT_W-1:0]         score [N_OUT];
  logic signed [ACC_W-1:0]  acc;

  logic [TERM_W-1:0]        last_term;
  logic [NRN_W-1:0]         last_nrn;
  logic [CA_W-1:0]          base;
  logic [HID_W-1:0]         x_op;
  logic signed [ACC_W-1:0]  x_s, w_s, prod;
  logic [HID_W-1:0]         hid_val;
  logic [OUT_W-1:0]         out_val;
  logic [1:0]               c0, win_cls;
  logic [OUT_W-1:0]         c0_val;

  assign last_term = layer ? TERM_W'(N_HID - 1) : TERM_W'(N_IN - 1);
  assign last_nrn  = layer ? NRN_W'(N_OUT - 1) : NRN_W'(N_HID - 1);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // Operand selection and the single signed MAC product (unsigned operand, signed weight).
  always_comb begin
    base = layer ? CA_W'(L1_BASE) + CA_W'(neuron) * CA_W'(N_HID + 1)
                 : CA_W'(neuron) * CA_W'(N_IN + 1);
    coef_addr = '0;
    if (state == BIAS)     coef_addr = base;
    else if (state == MAC) coef_addr = base + CA_W'(1) + CA_W'(term);
    x_op = layer ? hid[term[NRN_W-1:0]] : HID_W'(feat[term]);
    x_s  = signed'(ACC_W'(x_op));
    w_s  = ACC_W'(signed'(coef_data[W_W-1:0]));
    prod = x_s * w_s;
  end

  always_comb begin
    hid_val = acc[HID_W-1:0];
    out_val = acc[OUT_W-1:0];
`ifdef MLP_SEQ_SAT_EN
    if (acc > signed'(ACC_W'((1 << HID_W) - 1))) hid_val = '1;
    if (acc > signed'(ACC_W'((1 << OUT_W) - 1))) out_val = '1;
`endif
    if (acc < 0) begin
      hid_val = '0;
      out_val = '0;
    end
  end

  // Tie-to-lower argmax: s0 vs s1 first, the winner then against s2.
  always_comb begin
    c0      = (score[0] >= score[1]) ? 2'd0 : 2'd1;
    c0_val  = (score[0] >= score[1]) ? score[0] : score[1];
    win_cls = (c0_val >= score[2]) ? c0 : 2'd2;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = BIAS;
      BIAS:    state_nx = MAC;
      MAC:     if (term == last_term) state_nx = WB;
      WB:      state_nx = (neuron == last_nrn && layer) ? ARGMAX : BIAS;
      ARGMAX:  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these small register arrays are reset because an abort must leave no stale operands.
      for (int i = 0; i < N_IN; i++)  feat[i]  <= '0;
      for (int i = 0; i < N_HID; i++) hid[i]   <= '0;
      for (int i = 0; i < N_OUT; i++) score[i] <= '0;
      acc        <= '0;
      layer      <= 1'b0;
      neuron     <= '0;
      term       <= '0;
      out_class  <= '0;
      out_scores <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          for (int i = 0; i < N_IN; i++) feat[i] <= in_data[i*IN_W +: IN_W];
          layer  <= 1'b0;
          neuron <= '0;
        end
        BIAS: begin
          acc  <= signed'(coef_data);
          term <= '0;
        end
        MAC: begin
          acc  <= acc + prod;
          term <= term + 1'b1;
        end
        WB: begin
          if (!layer) hid[neuron]   <= hid_val;
          else        score[neuron] <= out_val;
          if (neuron == last_nrn) begin
            neuron <= '0;
            layer  <= 1'b1;
          end else begin
            neuron <= neuron + 1'b1;
          end
        end
        ARGMAX: begin
          out_class  <= win_cls;
          out_scores <= {score[0], score[1], score[2]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Scoreboard bench for mlp_seq_ctrl: random ROMs and features against a loop-level MLP model.
module tb_mlp_seq_ctrl;

  localparam int N_IN = 6, IN_W = 5, ACC_W = 20, OUT_W = 19, CA_W = 6;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [N_IN*IN_W-1:0]  in_data = '0;
  logic [CA_W-1:0]       coef_addr;
  logic [ACC_W-1:0]      coef_data;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [1:0]            out_class;
  logic [3*OUT_W-1:0]    out_scores;
  logic                  busy;

  mlp_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_addr(coef_addr), .coef_data(coef_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_scores(out_scores), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [ACC_W-1:0] rom [64];
  assign coef_data = rom[coef_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]         cls;
    logic [3*OUT_W-1:0] scores;
    int                 acc_cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t last_e;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b1;
  bit   sat_build;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer dot products, modulo-2^20 accumulator, ReLU, strict-greater argmax.
  function automatic exp_t model(input logic [N_IN*IN_W-1:0] d);
    exp_t              e;
    int                sum;
    logic signed [19:0] a20;
    logic [11:0]       h [3];
    logic [18:0]       s [3];
    int                best;
    for (int j = 0; j < 3; j++) begin
      sum = int'($signed(rom[j*7]));
      for (int i = 0; i < N_IN; i++)
        sum += int'(d[i*IN_W +: IN_W]) * int'($signed(rom[j*7+1+i][7:0]));
      a20 = sum[19:0];
      if (a20 < 0) h[j] = '0;
      else         h[j] = a20[11:0];
`ifdef MLP_SEQ_SAT_EN
      if (a20 > 4095) h[j] = '1;
`endif
    end
    for (int k = 0; k < 3; k++) begin
      sum = int'($signed(rom[21+k*4]));
      for (int i = 0; i < 3; i++)
        sum += int'(h[i]) * int'($signed(rom[21+k*4+1+i][7:0]));
      a20 = sum[19:0];
      if (a20 < 0) s[k] = '0;
      else         s[k] = a20[18:0];
    end
    best = 0;
    for (int k = 1; k < 3; k++) if (s[k] > s[best]) best = k;
    e.cls     = 2'(best);
    e.scores  = {s[0], s[1], s[2]};
    e.acc_cyc = 0;
    return e;
  endfunction

  // Monitor: pop on each rising out_valid, then watch hold stability and post-handshake retention.
  initial begin
    exp_t e;
    bit   vprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vprev = 1'b0;
      end else begin
        if (out_valid && !vprev) begin
          if (sbq.size() == 0) begin
            check("spurious_out_valid", 64'(out_valid), 64'd0);
          end else begin
            e = sbq.pop_front();
            last_e = e;
            check("out_class", 64'(out_class), 64'(e.cls));
            check("out_scores", 64'(out_scores), 64'(e.scores));
            check("latency", 64'(cyc - e.acc_cyc), 64'd40);
            check("in_ready_in_done", 64'(in_ready), 64'd0);
          end
        end else if (out_valid) begin
          check("hold_class", 64'(out_class), 64'(last_e.cls));
          check("hold_scores", 64'(out_scores), 64'(last_e.scores));
        end else if (vprev) begin
          check("kept_scores", 64'(out_scores), 64'(last_e.scores));
          check("kept_class", 64'(out_class), 64'(last_e.cls));
        end
        vprev = out_valid;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [N_IN*IN_W-1:0] d);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("accept_timeout", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_data   = d;
    e         = model(d);
    e.acc_cyc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Random traffic on the input while the sequencer is busy must be ignored.
  task automatic noise(input int n);
    repeat (n) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 30'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || !in_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      check("drain_queue", 64'(sbq.size()), 64'd0);
      check("drain_idle", 64'(in_ready), 64'd1);
    end
  endtask

  task automatic rom_clear();
    for (int a = 0; a < 64; a++) rom[a] = '0;
  endtask

  task automatic rom_random();
    rom_clear();
    for (int a = 0; a < 33; a++) rom[a] = 20'($urandom);
    for (int j = 0; j < 3; j++) rom[j*7]   = 20'(int'($urandom_range(0, 12000)) - 4000);
    for (int k = 0; k < 3; k++) rom[21+k*4] = 20'(int'($urandom_range(0, 60000)) - 20000);
  endtask

  initial begin
`ifdef MLP_SEQ_SAT_EN
    sat_build = 1'b1;
`else
    sat_build = 1'b0;
`endif
    rom_clear();
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_coef_addr", 64'(coef_addr), 64'd0);
    check("rst_out_class", 64'(out_class), 64'd0);
    check("rst_out_scores", 64'(out_scores), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random ROMs: all-zero, all-max and random feature vectors.
    for (int r = 0; r < 3; r++) begin
      rom_random();
      send('0);
      noise(30);
      send('1);
      noise(30);
      for (int v = 0; v < 4; v++) begin
        send(30'($urandom));
        noise(30);
      end
      drain();
    end

    // All-zero ROM: every score is zero and the tie resolves to class 0.
    rom_clear();
    for (int v = 0; v < 3; v++) send(30'($urandom));
    drain();
    check("zero_rom_class", 64'(out_class), 64'd0);
    check("zero_rom_scores", 64'(out_scores), 64'd0);

    // Consumer stall for 10 cycles, release, then a back-to-back vector.
    rom_random();
    rand_rdy  = 1'b0;
    out_ready = 1'b0;
    send(30'($urandom));
    begin
      int n = 0;
      while (!out_valid && n < 60) begin
        @(negedge clk);
        n++;
      end
      if (n >= 60) check("stall_wait_valid", 64'(out_valid), 64'd1);
    end
    repeat (10) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_in_ready", 64'(in_ready), 64'd1);
    send(30'($urandom));
    drain();
    rand_rdy = 1'b1;

    // Reset in the middle of a computation.
    send(30'($urandom));
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_coef_addr", 64'(coef_addr), 64'd0);
    check("abort_out_scores", 64'(out_scores), 64'd0);
    check("abort_out_class", 64'(out_class), 64'd0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort_idle", 64'(out_valid), 64'd0);
    send(30'($urandom));
    drain();

    // Oversized hidden value: bias 5000 with zero weights, routed straight into score 0.
    rom_clear();
    rom[0]  = 20'd5000;
    rom[22] = 20'd1;
    send(30'($urandom));
    drain();
    check("big_bias_score0", 64'(out_scores[3*OUT_W-1 -: OUT_W]), sat_build ? 64'd4095 : 64'd904);
    check("big_bias_class", 64'(out_class), 64'd0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
